controle_entrada_saida: RTL and testbench

Sequential I/O controller directly downstream of the instruction decoder. Consumes the decoder's `confirma_entrada`, `print` and `halt` strobes and drives the board I/O: it stalls the PC while an INPUT instruction waits for the user's debounced confirm button. It captures the switch value for register write-back, latches OUTPUT values for the display, and freezes the core on HALT.

---
 rtl/controle_entrada_saida_if.sv | 41 ++++
 rtl/controle_entrada_saida.sv | 148 ++++++++++++++
 tb/tb_controle_entrada_saida.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/controle_entrada_saida_if.sv
// ============================================================================
// Module   : controle_entrada_saida_if
// Brief    : Decoder/board-side signal bundle of the I/O controller.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface controle_entrada_saida_if #(
    parameter int DATA_W = 32,
    parameter int SW_W   = 16
);
    logic [1:0]        confirma_entrada;
    logic              print;
    logic              halt;
    logic [SW_W-1:0]   switches;
    logic              botao;
    logic [DATA_W-1:0] reg_data_in;
    logic [DATA_W-1:0] saved_pc;

    logic [DATA_W-1:0] dado_entrada;
    logic              wb_valid;
    logic              pc_stall;
    logic              aguardando_entrada;
    logic [DATA_W-1:0] display_valor;
    logic              display_valido;
    logic              halted;

    modport master (
        output confirma_entrada, print, halt, switches, botao, reg_data_in, saved_pc,
        input  dado_entrada, wb_valid, pc_stall, aguardando_entrada,
               display_valor, display_valido, halted
    );

    modport slave (
        input  confirma_entrada, print, halt, switches, botao, reg_data_in, saved_pc,
        output dado_entrada, wb_valid, pc_stall, aguardando_entrada,
               display_valor, display_valido, halted
    );
endinterface

`default_nettype wire

// File: rtl/controle_entrada_saida.sv
// ============================================================================
// Module   : controle_entrada_saida
// Brief    : I/O controller: INPUT stall/capture, OUTPUT display latch, HALT.
// Revision : 1.0
// ============================================================================
`default_nettype none

module controle_entrada_saida #(
    parameter int DATA_W     = 32,
    parameter int SW_W       = 16,
    parameter int DEB_CYCLES = 4
) (
    input  wire logic               clk,
    input  wire logic               reset,
    controle_entrada_saida_if.slave io
);

    localparam int CNT_W = $clog2(DEB_CYCLES + 1);
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    typedef enum logic [2:0] {
        OCIOSO        = 3'd0,
        ESPERA_SOLTA  = 3'd1,
        ESPERA_APERTA = 3'd2,
        CAPTURA       = 3'd3,
        PARADO        = 3'd4
    } estado_t;

    estado_t           estado_q;
    logic              sync1_q;
    logic              sync2_q;
    logic              deb_q;
    logic              deb_prev_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [DATA_W-1:0] captura_q;
    logic [DATA_W-1:0] display_valor_q;
    logic              display_valido_q;

    logic              w_deb_rise;
    logic              w_input;
    logic              w_recover;
    logic              w_pc_stall;
    logic              w_wb_valid;
    logic              w_aguardando;
    logic [DATA_W-1:0] w_dado;

    assign w_deb_rise = deb_q & ~deb_prev_q;
    assign w_input    = (io.confirma_entrada == 2'd1);
    assign w_recover  = (io.confirma_entrada == 2'd2);

    // Debounced level only flips after DEB_CYCLES consecutive disagreeing samples.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            deb_q      <= 1'b0;
            deb_prev_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            sync1_q    <= io.botao;
            sync2_q    <= sync1_q;
            deb_prev_q <= deb_q;
            if (sync2_q == deb_q) begin
                cnt_q <= '0;
            end else if (cnt_q == C_CNT_LAST) begin
                deb_q <= ~deb_q;
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            estado_q         <= OCIOSO;
            captura_q        <= '0;
            display_valor_q  <= '0;
            display_valido_q <= 1'b0;
        end else begin
            case (estado_q)
                OCIOSO: begin
                    if (io.halt) begin
                        estado_q <= PARADO;
                    end else if (w_input) begin
                        estado_q <= deb_q ? ESPERA_SOLTA : ESPERA_APERTA;
                    end else if (!w_recover && io.print) begin
                        display_valor_q  <= io.reg_data_in;
                        display_valido_q <= 1'b1;
                    end
                end
                // A button still held from earlier must be released first.
                ESPERA_SOLTA: begin
                    if (!deb_q) begin
                        estado_q <= ESPERA_APERTA;
                    end
                end
                ESPERA_APERTA: begin
                    if (w_deb_rise) begin
                        captura_q <= DATA_W'(io.switches);
                        estado_q  <= CAPTURA;
                    end
                end
                CAPTURA: estado_q <= OCIOSO;
                PARADO:  estado_q <= PARADO;
                default: estado_q <= OCIOSO;
            endcase
        end
    end

    always_comb begin
        w_pc_stall   = 1'b0;
        w_wb_valid   = 1'b0;
        w_aguardando = 1'b0;
        w_dado       = '0;
        case (estado_q)
            OCIOSO: begin
                if (io.halt || w_input) begin
                    w_pc_stall = 1'b1;
                end else if (w_recover) begin
                    w_wb_valid = 1'b1;
                    w_dado     = io.saved_pc;
                end
            end
            ESPERA_SOLTA, ESPERA_APERTA: begin
                w_pc_stall   = 1'b1;
                w_aguardando = 1'b1;
            end
            CAPTURA: begin
                w_wb_valid = 1'b1;
                w_dado     = captura_q;
            end
            PARADO:  w_pc_stall = 1'b1;
            default: w_pc_stall = 1'b0;
        endcase
    end

    assign io.pc_stall           = w_pc_stall;
    assign io.wb_valid           = w_wb_valid;
    assign io.dado_entrada       = w_dado;
    assign io.aguardando_entrada = w_aguardando;
    assign io.display_valor      = display_valor_q;
    assign io.display_valido     = display_valido_q;
    assign io.halted             = (estado_q == PARADO);

endmodule

`default_nettype wire

// File: tb/tb_controle_entrada_saida.sv
// ============================================================================
// Module   : tb_controle_entrada_saida
// Brief    : Scoreboard bench for the I/O controller (directed vectors).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_controle_entrada_saida;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    logic [31:0] wb_exp_q[$];
    logic [31:0] disp_exp_q[$];
    logic [31:0] last_val;
    logic        last_vld;
    logic [31:0] mon_exp;

    controle_entrada_saida_if #(.DATA_W(32), .SW_W(16)) b ();

    controle_entrada_saida #(
        .DATA_W(32), .SW_W(16), .DEB_CYCLES(4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .io    (b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_dado"},      b.dado_entrada, 32'h0);
        chk({tag, "_wb"},        32'(b.wb_valid), 32'h0);
        chk({tag, "_stall"},     32'(b.pc_stall), 32'h0);
        chk({tag, "_led"},       32'(b.aguardando_entrada), 32'h0);
        chk({tag, "_disp"},      b.display_valor, 32'h0);
        chk({tag, "_disp_vld"},  32'(b.display_valido), 32'h0);
        chk({tag, "_halted"},    32'(b.halted), 32'h0);
    endtask

    // Starts at a drive point; returns at the negedge of the write-back cycle.
    task automatic wait_capture(input int budget);
        bit got = 0;
        for (int i = 0; i < budget && !got; i++) begin
            smp();
            if (b.wb_valid) begin
                got = 1;
                chk("capture_stall", 32'(b.pc_stall), 32'h0);
                chk("capture_led",   32'(b.aguardando_entrada), 32'h0);
            end else begin
                chk("wait_stall", 32'(b.pc_stall), 32'h1);
                cyc();
            end
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL capture_timeout: got no wb_valid in %0d cycles expected capture", budget);
        end
    endtask

    // Monitor: pops expectations whenever the DUT writes back or updates the display.
    always @(negedge clk) begin
        if (reset) begin
            last_val = b.display_valor;
            last_vld = b.display_valido;
        end else begin
            if (b.wb_valid) begin
                if (wb_exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL wb_unexpected: got dado_entrada=%h expected no write-back", b.dado_entrada);
                end else begin
                    mon_exp = wb_exp_q.pop_front();
                    chk("wb_data", b.dado_entrada, mon_exp);
                end
            end else begin
                chk("dado_idle_zero", b.dado_entrada, 32'h0);
            end
            if (b.display_valor !== last_val || b.display_valido !== last_vld) begin
                if (disp_exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL disp_unexpected: got display_valor=%h expected unchanged %h", b.display_valor, last_val);
                end else begin
                    mon_exp = disp_exp_q.pop_front();
                    chk("disp_data",  b.display_valor, mon_exp);
                    chk("disp_valid", 32'(b.display_valido), 32'h1);
                end
            end
            last_val = b.display_valor;
            last_vld = b.display_valido;
        end
    end

    initial begin
        b.confirma_entrada = 2'd0;
        b.print            = 1'b0;
        b.halt             = 1'b0;
        b.switches         = 16'h0;
        b.botao            = 1'b0;
        b.reg_data_in      = 32'h0;
        b.saved_pc         = 32'h0;

        repeat (3) cyc();
        smp();
        check_all_zero("reset");
        cyc();
        reset = 1'b0;

        // INPUT with a fresh press held 10 cycles
        cyc();
        b.confirma_entrada = 2'd1;
        b.switches         = 16'h00A5;
        b.botao            = 1'b1;
        wb_exp_q.push_back(32'h0000_00A5);
        wait_capture(30);
        cyc();
        b.confirma_entrada = 2'd0;
        smp();
        chk("in1_after_led",   32'(b.aguardando_entrada), 32'h0);
        chk("in1_after_stall", 32'(b.pc_stall), 32'h0);
        repeat (2) cyc();
        b.botao = 1'b0;
        repeat (8) cyc();

        // INPUT while button already held, then a short glitch, then a real press
        b.botao = 1'b1;
        repeat (8) cyc();
        b.confirma_entrada = 2'd1;
        b.switches         = 16'h1234;
        wb_exp_q.push_back(32'h0000_1234);
        smp();
        chk("held_stall", 32'(b.pc_stall), 32'h1);
        for (int i = 0; i < 5; i++) begin
            cyc();
            smp();
            chk("held_no_wb", 32'(b.wb_valid), 32'h0);
            chk("held_led",   32'(b.aguardando_entrada), 32'h1);
        end
        cyc();
        b.botao = 1'b0;
        for (int i = 0; i < 8; i++) begin
            smp();
            chk("release_no_wb", 32'(b.wb_valid), 32'h0);
            chk("release_stall", 32'(b.pc_stall), 32'h1);
            cyc();
        end
        b.botao = 1'b1;
        cyc();
        cyc();
        b.botao = 1'b0;
        for (int i = 0; i < 10; i++) begin
            smp();
            chk("glitch_no_wb", 32'(b.wb_valid), 32'h0);
            chk("glitch_stall", 32'(b.pc_stall), 32'h1);
            cyc();
        end
        b.botao = 1'b1;
        wait_capture(30);
        cyc();
        b.confirma_entrada = 2'd0;
        smp();
        chk("in2_after_stall", 32'(b.pc_stall), 32'h0);
        cyc();
        b.botao = 1'b0;
        repeat (8) cyc();

        // recover-PC: same-cycle write-back, no stall
        b.saved_pc         = 32'h0000_0040;
        b.confirma_entrada = 2'd2;
        wb_exp_q.push_back(32'h0000_0040);
        smp();
        chk("rpc_wb",    32'(b.wb_valid), 32'h1);
        chk("rpc_dado",  b.dado_entrada, 32'h0000_0040);
        chk("rpc_stall", 32'(b.pc_stall), 32'h0);
        cyc();
        b.confirma_entrada = 2'd3;
        smp();
        chk("c3_stall", 32'(b.pc_stall), 32'h0);
        chk("c3_wb",    32'(b.wb_valid), 32'h0);
        cyc();
        b.confirma_entrada = 2'd0;
        smp();
        chk("c3_led", 32'(b.aguardando_entrada), 32'h0);

        // print: display updated one edge later, then overwritten
        cyc();
        b.print       = 1'b1;
        b.reg_data_in = 32'hDEAD_BEEF;
        disp_exp_q.push_back(32'hDEAD_BEEF);
        smp();
        chk("print_latency", b.display_valor, 32'h0);
        chk("print_stall",   32'(b.pc_stall), 32'h0);
        cyc();
        b.print = 1'b0;
        smp();
        chk("print1_val", b.display_valor, 32'hDEAD_BEEF);
        chk("print1_vld", 32'(b.display_valido), 32'h1);
        cyc();
        b.print       = 1'b1;
        b.reg_data_in = 32'h0000_0007;
        disp_exp_q.push_back(32'h0000_0007);
        cyc();
        b.print = 1'b0;
        smp();
        chk("print2_val", b.display_valor, 32'h0000_0007);

        // recover-PC outranks print in the same cycle
        cyc();
        b.confirma_entrada = 2'd2;
        b.print            = 1'b1;
        b.reg_data_in      = 32'h0000_0099;
        wb_exp_q.push_back(32'h0000_0040);
        cyc();
        b.confirma_entrada = 2'd0;
        b.print            = 1'b0;
        smp();
        chk("prio_disp", b.display_valor, 32'h0000_0007);

        // halt: stall now, halted next cycle, everything else ignored
        cyc();
        b.halt = 1'b1;
        smp();
        chk("halt_stall_now", 32'(b.pc_stall), 32'h1);
        chk("halt_not_yet",   32'(b.halted), 32'h0);
        cyc();
        b.halt = 1'b0;
        smp();
        chk("halted",         32'(b.halted), 32'h1);
        chk("halted_stall",   32'(b.pc_stall), 32'h1);
        cyc();
        b.confirma_entrada = 2'd1;
        b.print            = 1'b1;
        b.reg_data_in      = 32'h0000_1111;
        b.botao            = 1'b1;
        for (int i = 0; i < 12; i++) begin
            smp();
            chk("parado_no_wb",  32'(b.wb_valid), 32'h0);
            chk("parado_halted", 32'(b.halted), 32'h1);
            chk("parado_led",    32'(b.aguardando_entrada), 32'h0);
            cyc();
        end
        b.confirma_entrada = 2'd0;
        b.print            = 1'b0;
        b.botao            = 1'b0;
        smp();
        chk("parado_disp", b.display_valor, 32'h0000_0007);
        cyc();
        reset = 1'b1;
        cyc();
        smp();
        check_all_zero("halt_reset");
        cyc();
        reset = 1'b0;
        repeat (8) cyc();

        // reset while waiting for the button abandons the INPUT
        b.print       = 1'b1;
        b.reg_data_in = 32'h0000_0055;
        disp_exp_q.push_back(32'h0000_0055);
        cyc();
        b.print            = 1'b0;
        b.confirma_entrada = 2'd1;
        b.switches         = 16'h0005;
        cyc();
        smp();
        chk("midwait_led", 32'(b.aguardando_entrada), 32'h1);
        cyc();
        reset              = 1'b1;
        b.confirma_entrada = 2'd0;
        cyc();
        smp();
        check_all_zero("midwait_reset");
        cyc();
        reset   = 1'b0;
        b.botao = 1'b1;
        for (int i = 0; i < 12; i++) begin
            smp();
            chk("post_reset_no_wb", 32'(b.wb_valid), 32'h0);
            chk("post_reset_stall", 32'(b.pc_stall), 32'h0);
            cyc();
        end
        b.botao = 1'b0;
        repeat (4) cyc();

        chk("wb_queue_empty",   32'(wb_exp_q.size()), 32'h0);
        chk("disp_queue_empty", 32'(disp_exp_q.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
